// File: rtl/decode_pkg.sv
// Shared types and encodings for the RV64IM field decoder: operation IDs,
// instruction formats, major opcodes, counter CSR numbers and the decoded record.
package decode_pkg;

    typedef enum logic [6:0] {
        OP_ILLEGAL = 7'd0,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK,
        OP_RDCYCLE, OP_RDCYCLEH, OP_RDTIME, OP_RDTIMEH,
        OP_RDINSTRET, OP_RDINSTRETH,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_e;

    typedef enum logic [2:0] {
        IT_ILL = 3'd0,
        IT_R   = 3'd1,
        IT_I   = 3'd2,
        IT_S   = 3'd3,
        IT_B   = 3'd4,
        IT_U   = 3'd5,
        IT_J   = 3'd6
    } itype_e;

    // Major opcodes include bits [1:0] = 2'b11, so a compressed word never matches.
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_TIME     = 12'hC01;
    localparam logic [11:0] CSR_TIMEH    = 12'hC81;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH = 12'hC82;

    typedef struct packed {
        op_e         op_id;
        itype_e      itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [63:0] imm;
        logic        flag;
    } decoded_t;

endpackage

// File: rtl/inst_decode_comb.sv
// Purely combinational RV64IM decoder: one 32-bit word in, operation ID,
// format, register indices and sign-extended immediate out.
module inst_decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instruction,
    output decoded_t    dec_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    op_e         op;
    itype_e      fmt;
    logic [63:0] imm_sel;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
    assign imm_b = {{52{instruction[31]}}, instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};
    assign imm_u = {{32{instruction[31]}}, instruction[31:12], 12'b0};
    assign imm_j = {{44{instruction[31]}}, instruction[19:12], instruction[20],
                    instruction[30:21], 1'b0};

    always_comb begin
        // NOTE: every output gets a default up front so no path can infer a latch.
        op      = OP_ILLEGAL;
        fmt     = IT_ILL;
        imm_sel = '0;
        case (opcode)
            OPC_LUI:   begin op = OP_LUI;   fmt = IT_U; imm_sel = imm_u; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = IT_U; imm_sel = imm_u; end
            OPC_JAL:   begin op = OP_JAL;   fmt = IT_J; imm_sel = imm_j; end
            OPC_JALR: begin
                fmt = IT_I; imm_sel = imm_i;
                if (funct3 == 3'd0) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = IT_B; imm_sel = imm_b;
                case (funct3)
                    3'd0: op = OP_BEQ;
                    3'd1: op = OP_BNE;
                    3'd4: op = OP_BLT;
                    3'd5: op = OP_BGE;
                    3'd6: op = OP_BLTU;
                    3'd7: op = OP_BGEU;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                fmt = IT_I; imm_sel = imm_i;
                case (funct3)
                    3'd0: op = OP_LB;
                    3'd1: op = OP_LH;
                    3'd2: op = OP_LW;
                    3'd3: op = OP_LD;
                    3'd4: op = OP_LBU;
                    3'd5: op = OP_LHU;
                    3'd6: op = OP_LWU;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                fmt = IT_S; imm_sel = imm_s;
                case (funct3)
                    3'd0: op = OP_SB;
                    3'd1: op = OP_SH;
                    3'd2: op = OP_SW;
                    3'd3: op = OP_SD;
                    default: ;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = IT_I; imm_sel = imm_i;
                case (funct3)
                    3'd0: op = OP_ADDI;
                    3'd2: op = OP_SLTI;
                    3'd3: op = OP_SLTIU;
                    3'd4: op = OP_XORI;
                    3'd6: op = OP_ORI;
                    3'd7: op = OP_ANDI;
                    3'd1: begin
                        imm_sel = {58'd0, instruction[25:20]};
                        if (instruction[31:26] == 6'b000000) op = OP_SLLI;
                    end
                    3'd5: begin
                        imm_sel = {58'd0, instruction[25:20]};
                        if (instruction[31:26] == 6'b000000)      op = OP_SRLI;
                        else if (instruction[31:26] == 6'b010000) op = OP_SRAI;
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                fmt = IT_R;
                case (funct7)
                    7'h00: case (funct3)
                        3'd0: op = OP_ADD;
                        3'd1: op = OP_SLL;
                        3'd2: op = OP_SLT;
                        3'd3: op = OP_SLTU;
                        3'd4: op = OP_XOR;
                        3'd5: op = OP_SRL;
                        3'd6: op = OP_OR;
                        default: op = OP_AND;
                    endcase
                    7'h20: case (funct3)
                        3'd0: op = OP_SUB;
                        3'd5: op = OP_SRA;
                        default: ;
                    endcase
                    7'h01: case (funct3)
                        3'd0: op = OP_MUL;
                        3'd1: op = OP_MULH;
                        3'd2: op = OP_MULHSU;
                        3'd3: op = OP_MULHU;
                        3'd4: op = OP_DIV;
                        3'd5: op = OP_DIVU;
                        3'd6: op = OP_REM;
                        default: op = OP_REMU;
                    endcase
                    default: ;
                endcase
            end
            OPC_OP_IMM_32: begin
                // Word shifts carry a 5-bit shamt; bit 25 set is covered by the funct7 match.
                fmt = IT_I;
                case (funct3)
                    3'd0: begin op = OP_ADDIW; imm_sel = imm_i; end
                    3'd1: begin
                        imm_sel = {59'd0, instruction[24:20]};
                        if (funct7 == 7'h00) op = OP_SLLIW;
                    end
                    3'd5: begin
                        imm_sel = {59'd0, instruction[24:20]};
                        if (funct7 == 7'h00)      op = OP_SRLIW;
                        else if (funct7 == 7'h20) op = OP_SRAIW;
                    end
                    default: ;
                endcase
            end
            OPC_OP_32: begin
                fmt = IT_R;
                case (funct7)
                    7'h00: case (funct3)
                        3'd0: op = OP_ADDW;
                        3'd1: op = OP_SLLW;
                        3'd5: op = OP_SRLW;
                        default: ;
                    endcase
                    7'h20: case (funct3)
                        3'd0: op = OP_SUBW;
                        3'd5: op = OP_SRAW;
                        default: ;
                    endcase
                    7'h01: case (funct3)
                        3'd0: op = OP_MULW;
                        3'd4: op = OP_DIVW;
                        3'd5: op = OP_DIVUW;
                        3'd6: op = OP_REMW;
                        3'd7: op = OP_REMUW;
                        default: ;
                    endcase
                    default: ;
                endcase
            end
            OPC_MISC_MEM: begin
                fmt = IT_I; imm_sel = imm_i;
                if (funct3 == 3'd0)      op = OP_FENCE;
                else if (funct3 == 3'd1) op = OP_FENCE_I;
            end
            OPC_SYSTEM: begin
                fmt = IT_I;
                if (instruction == 32'h0000_0073) begin
                    op = OP_ECALL;
                end else if (instruction == 32'h0010_0073) begin
                    op = OP_EBREAK; imm_sel = imm_i;
                end else if (funct3 == 3'b010 && instruction[19:15] == 5'd0) begin
                    // Only CSRRS rd, <counter>, x0 is supported; imm carries the CSR number.
                    imm_sel = {52'd0, instruction[31:20]};
                    case (instruction[31:20])
                        CSR_CYCLE:    op = OP_RDCYCLE;
                        CSR_CYCLEH:   op = OP_RDCYCLEH;
                        CSR_TIME:     op = OP_RDTIME;
                        CSR_TIMEH:    op = OP_RDTIMEH;
                        CSR_INSTRET:  op = OP_RDINSTRET;
                        CSR_INSTRETH: op = OP_RDINSTRETH;
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
        if (op == OP_ILLEGAL) begin
            fmt     = IT_ILL;
            imm_sel = '0;
        end
    end

    always_comb begin
        dec_o.op_id = op;
        dec_o.itype = fmt;
        dec_o.imm   = imm_sel;
        dec_o.flag  = (op != OP_ILLEGAL);
        dec_o.rd    = (fmt inside {IT_R, IT_I, IT_U, IT_J}) ? instruction[11:7]  : 5'd0;
        dec_o.rs1   = (fmt inside {IT_R, IT_I, IT_S, IT_B}) ? instruction[19:15] : 5'd0;
        dec_o.rs2   = (fmt inside {IT_R, IT_S, IT_B})       ? instruction[24:20] : 5'd0;
        if (op inside {OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK}) begin
            dec_o.rd  = 5'd0;
            dec_o.rs1 = 5'd0;
            dec_o.rs2 = 5'd0;
        end
    end

endmodule

// File: rtl/get_variables.sv
// Registered wrapper around inst_decode_comb: decoded fields appear one cycle
// after an accepted word and hold while no new word is offered.
module get_variables
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [6:0]  op_id,
    output logic [2:0]  instruction_type,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [63:0] imm,
    output logic        flag
);

    decoded_t dec_comb;
    decoded_t dec_d, dec_q;
    logic     out_valid_d, out_valid_q;

    inst_decode_comb u_decode (
        .instruction (instruction),
        .dec_o       (dec_comb)
    );

    always_comb begin
        out_valid_d = in_valid;
        dec_d       = in_valid ? dec_comb : dec_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            out_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            dec_q       <= dec_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign op_id            = dec_q.op_id;
    assign instruction_type = dec_q.itype;
    assign rd               = dec_q.rd;
    assign rs1              = dec_q.rs1;
    assign rs2              = dec_q.rs2;
    assign imm              = dec_q.imm;
    assign flag             = dec_q.flag;

endmodule

// File: tb/tb_get_variables.sv
// Directed bench for get_variables: a table of hand-decoded words streamed
// back-to-back, plus reset, hold and restart sequences.
module tb_get_variables;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [6:0]  op_id;
    logic [2:0]  instruction_type;
    logic [4:0]  rd, rs1, rs2;
    logic [63:0] imm;
    logic        flag;

    get_variables dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .instruction      (instruction),
        .out_valid        (out_valid),
        .op_id            (op_id),
        .instruction_type (instruction_type),
        .rd               (rd),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm              (imm),
        .flag             (flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [2:0]  typ;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm;
        logic        flag;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [89:0] outs();
        return {op_id, instruction_type, rd, rs1, rs2, imm, flag};
    endfunction

    function automatic logic [89:0] exp_of(input vec_t v);
        return {v.op, v.typ, v.rd, v.rs1, v.rs2, v.imm, v.flag};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] w, input int op, input int typ,
                                input int d, input int s1, input int s2, input logic [63:0] im,
                                input logic f);
        vec_t v;
        v.name = n; v.instr = w; v.op = 7'(op); v.typ = 3'(typ);
        v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2); v.imm = im; v.flag = f;
        return v;
    endfunction

    vec_t last;

    initial begin
        vecs.push_back(mk("addi",      32'h00500093, 22, 2, 1, 0, 0, 64'd5, 1));
        vecs.push_back(mk("add",       32'h002081B3, 31, 1, 3, 1, 2, 64'd0, 1));
        vecs.push_back(mk("sw_neg",    32'hFE20AE23, 20, 3, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, 1));
        vecs.push_back(mk("lui_pos",   32'h123452B7, 1, 5, 5, 0, 0, 64'h0000_0000_1234_5000, 1));
        vecs.push_back(mk("lui_neg",   32'h800002B7, 1, 5, 5, 0, 0, 64'hFFFF_FFFF_8000_0000, 1));
        vecs.push_back(mk("all_ones",  32'hFFFFFFFF, 0, 0, 0, 0, 0, 64'd0, 0));
        vecs.push_back(mk("all_zero",  32'h00000000, 0, 0, 0, 0, 0, 64'd0, 0));
        vecs.push_back(mk("sub",       32'h407302B3, 32, 1, 5, 6, 7, 64'd0, 1));
        vecs.push_back(mk("mul",       32'h02C58533, 60, 1, 10, 11, 12, 64'd0, 1));
        vecs.push_back(mk("srai63",    32'h43F15093, 30, 2, 1, 2, 0, 64'd63, 1));
        vecs.push_back(mk("sraiw",     32'h4052519B, 54, 2, 3, 4, 0, 64'd5, 1));
        vecs.push_back(mk("slliw_b25", 32'h0200109B, 0, 0, 0, 0, 0, 64'd0, 0));
        vecs.push_back(mk("beq_neg",   32'hFE208EE3, 5, 4, 0, 1, 2, 64'hFFFF_FFFF_FFFF_FFFC, 1));
        vecs.push_back(mk("jal_800",   32'h001000EF, 3, 6, 1, 0, 0, 64'h800, 1));
        vecs.push_back(mk("rdcycle",   32'hC00022F3, 45, 2, 5, 0, 0, 64'hC00, 1));
        vecs.push_back(mk("csr_other", 32'h300022F3, 0, 0, 0, 0, 0, 64'd0, 0));
        vecs.push_back(mk("ecall",     32'h00000073, 43, 2, 0, 0, 0, 64'd0, 1));
        vecs.push_back(mk("ld",        32'h00813203, 17, 2, 4, 2, 0, 64'd8, 1));
        vecs.push_back(mk("remuw",     32'h023170BB, 72, 1, 1, 2, 3, 64'd0, 1));
        vecs.push_back(mk("fence_i",   32'h0000100F, 42, 2, 0, 0, 0, 64'd0, 1));
        vecs.push_back(mk("c_li",      32'h00004501, 0, 0, 0, 0, 0, 64'd0, 0));

        reset = 1'b0; in_valid = 1'b0; instruction = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_state", {out_valid, outs()}, '0);

        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {out_valid, outs()}, '0);

        // Stream the table back-to-back; each word is checked one edge after it is offered.
        foreach (vecs[k]) begin
            in_valid    = 1'b1;
            instruction = vecs[k].instr;
            if (k == 0) begin
                #1 check("pre_edge_no_output", {out_valid, outs()}, '0);
            end
            @(negedge clk);
            check({vecs[k].name, "_fields"}, outs(), exp_of(vecs[k]));
            check({vecs[k].name, "_valid"}, out_valid, 1'b1);
        end
        last = vecs[vecs.size()-1];

        in_valid    = 1'b0;
        instruction = 32'h002081B3;
        @(negedge clk);
        check("idle_valid_low", out_valid, 1'b0);
        check("idle_hold_fields", outs(), exp_of(last));

        // Reset asserted between edges with a word in flight.
        in_valid    = 1'b1;
        instruction = vecs[0].instr;
        @(posedge clk);
        #2 check("loaded_before_reset", {out_valid, outs()}, {1'b1, exp_of(vecs[0])});
        reset = 1'b0;
        #1 check("async_reset_clear", {out_valid, outs()}, '0);
        @(negedge clk);
        @(negedge clk);
        check("reset_held_clear", {out_valid, outs()}, '0);

        reset       = 1'b1;
        in_valid    = 1'b0;
        instruction = vecs[1].instr;
        @(negedge clk);
        check("release_no_valid", {out_valid, outs()}, '0);
        @(negedge clk);
        check("release_no_valid_2", {out_valid, outs()}, '0);

        in_valid = 1'b1;
        @(negedge clk);
        check("first_after_release", {out_valid, outs()}, {1'b1, exp_of(vecs[1])});
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
